// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_clock_ctrl shared definitions
// state encodings and parameter defaults
package cpu_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_HALT  = 2'd3
   } cpu_state_t;

   localparam int DEB_CYCLES_DEF  = 1000000;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// btn_debounce: synchroniser + stability debouncer
// emits one pulse per accepted press
module btn_debounce
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk_in,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   raw_s;

   assign raw_s = sync_q[SYNC_STAGES-1];

   // sync the raw level, accept it after DEB_CYCLES stable cycles
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         btn_level <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw};
         btn_pulse <= 1'b0;
         if (raw_s == btn_level) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            cnt_q     <= '0;
            btn_level <= raw_s;
            btn_pulse <= raw_s;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: turns the divider tick into a CPU enable
// with run/pause, single-step, halt and a cycle counter
module cpu_clock_ctrl
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             tick_clk,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             halt_req,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
);

   logic [SYNC_STAGES-1:0] tick_sync_q;
   logic                   tick_d_q;
   logic                   tick_p;
   logic                   run_p;
   logic                   step_p;
   logic                   run_lvl;
   logic                   step_lvl;
   logic                   unused_lvl;
   cpu_state_t             state_q;
   cpu_state_t             state_d;
   logic                   en_d;

   assign unused_lvl = run_lvl ^ step_lvl;
   assign state      = state_q;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_run_deb (
      .clk_in   (clk_in),
      .rst      (rst),
      .btn_raw  (run_btn),
      .btn_level(run_lvl),
      .btn_pulse(run_p)
   );

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_step_deb (
      .clk_in   (clk_in),
      .rst      (rst),
      .btn_raw  (step_btn),
      .btn_level(step_lvl),
      .btn_pulse(step_p)
   );

   // sync tick_clk and register a one-cycle rising-edge pulse
   always_ff @(posedge clk_in) begin
      if (rst) begin
         tick_sync_q <= '0;
         tick_d_q    <= 1'b0;
         tick_p      <= 1'b0;
      end else begin
         tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_clk};
         tick_d_q    <= tick_sync_q[SYNC_STAGES-1];
         tick_p      <= tick_sync_q[SYNC_STAGES-1] & ~tick_d_q;
      end
   end

   // next state and enable; priority halt > run > step > tick
   always_comb begin
      state_d = state_q;
      en_d    = 1'b0;
      unique case (state_q)
         ST_PAUSE: begin
            if (halt_req)    state_d = ST_HALT;
            else if (run_p)  state_d = ST_RUN;
            else if (step_p) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (halt_req)    state_d = ST_HALT;
            else if (run_p)  state_d = ST_PAUSE;
            else if (tick_p) en_d    = 1'b1;
         end
         ST_STEP: begin
            if (halt_req)   state_d = ST_HALT;
            else if (run_p) state_d = ST_RUN;
            else if (tick_p) begin
               en_d    = 1'b1;
               state_d = ST_PAUSE;
            end
         end
         ST_HALT: begin
            if (!halt_req) begin
               if (run_p)       state_d = ST_RUN;
               else if (step_p) state_d = ST_STEP;
            end
         end
         default: state_d = ST_PAUSE;
      endcase
   end

   // state register, registered outputs and cycle counter
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= ST_PAUSE;
         cpu_en    <= 1'b0;
         running   <= 1'b0;
         halted    <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         state_q <= state_d;
         cpu_en  <= en_d;
         running <= (state_d == ST_RUN);
         halted  <= (state_d == ST_HALT);
         if (en_d) cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: randomized scenario bench
// with a count/state reference model
module tb_cpu_clock_ctrl;

   localparam int CNT_W = 4;
   localparam int MODN  = 16;

   logic             clk_in = 1'b0;
   logic             rst = 1'b1;
   logic             tick_clk = 1'b0;
   logic             run_btn = 1'b0;
   logic             step_btn = 1'b0;
   logic             halt_req = 1'b0;
   logic             cpu_en;
   logic             running;
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   int edge_n = 0;

   cpu_clock_ctrl #(
      .DEB_CYCLES (4),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(2)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .tick_clk (tick_clk),
      .run_btn  (run_btn),
      .step_btn (step_btn),
      .halt_req (halt_req),
      .cpu_en   (cpu_en),
      .running  (running),
      .halted   (halted),
      .state    (state),
      .cycle_cnt(cycle_cnt)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) edge_n <= edge_n + 1;

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic press(input bit r, input bit s, input int n);
      run_btn  = r;
      step_btn = s;
      step(n);
      run_btn  = 1'b0;
      step_btn = 1'b0;
      step(12);
   endtask

   // n tick periods; per=0 gives random period 6..14, else fixed per
   task automatic run_ticks(input int n, input int per,
                            output int total, output int badlag,
                            output int dbl);
      int hi, lo, start, lag;
      bit prev;
      total = 0; badlag = 0; dbl = 0; prev = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (per == 0) begin
            hi = $urandom_range(3, 7);
            lo = $urandom_range(3, 7);
         end else begin
            hi = $urandom_range(3, per - 3);
            lo = per - hi;
         end
         tick_clk = 1'b1;
         start = edge_n;
         lag = -1;
         for (int i = 0; i < hi + lo; i++) begin
            step(1);
            if (cpu_en === 1'b1) begin
               total++;
               if (lag < 0) lag = edge_n - start;
               if (prev) dbl++;
            end
            prev = (cpu_en === 1'b1);
            if (i + 1 == hi) tick_clk = 1'b0;
         end
         if (lag >= 0 && lag != 4) badlag++;
      end
   endtask

   task automatic test_reset();
      int tot, bl, db;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick_clk = (i == 1);
         step(1);
         checks++;
         if (cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: got %b expected 0", cpu_en);
         end
      end
      tick_clk = 1'b0;
      step(1);
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", state);
      end
      checks++;
      if (cycle_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt);
      end
      checks++;
      if (running !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b%b expected 00", running, halted);
      end
      rst = 1'b0;
      run_ticks(3, 0, tot, bl, db);
      checks++;
      if (tot != 0) begin
         errors++;
         $display("FAIL pause_no_en: got %0d expected 0", tot);
      end
   endtask

   task automatic test_run();
      int tot, bl, db;
      press(1'b1, 1'b0, 10);
      checks++;
      if (state !== 2'd1 || running !== 1'b1) begin
         errors++;
         $display("FAIL run_state: got %0d/%b expected 1/1", state, running);
      end
      run_ticks(5, 20, tot, bl, db);
      exp_cnt = (exp_cnt + 5) % MODN;
      checks++;
      if (tot != 5) begin
         errors++;
         $display("FAIL run_pulses: got %0d expected 5", tot);
      end
      checks++;
      if (bl != 0) begin
         errors++;
         $display("FAIL run_lag: got %0d bad expected 0", bl);
      end
      checks++;
      if (db != 0) begin
         errors++;
         $display("FAIL run_width: got %0d wide expected 0", db);
      end
      checks++;
      if (cycle_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL run_cnt: got %0d expected %0d", cycle_cnt, exp_cnt);
      end
   endtask

   task automatic test_step();
      int tot, bl, db;
      press(1'b1, 1'b0, 10);
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL pause_state: got %0d expected 0", state);
      end
      press(1'b0, 1'b1, 10);
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL step_state: got %0d expected 2", state);
      end
      run_ticks(3, 20, tot, bl, db);
      exp_cnt = (exp_cnt + 1) % MODN;
      checks++;
      if (tot != 1 || bl != 0) begin
         errors++;
         $display("FAIL step_pulses: got %0d lagbad %0d expected 1 0", tot, bl);
      end
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL step_back: got %0d expected 0", state);
      end
      checks++;
      if (cycle_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL step_cnt: got %0d expected %0d", cycle_cnt, exp_cnt);
      end
   endtask

   task automatic test_bounce();
      int changes, cyc, len;
      logic [1:0] prevst;
      bit lvl;
      changes = 0; cyc = 0; lvl = 1'b0; prevst = state;
      while (cyc < 20) begin
         lvl = ~lvl;
         run_btn = lvl;
         len = $urandom_range(1, 3);
         for (int i = 0; i < len; i++) begin
            step(1);
            if (state !== prevst) changes++;
            prevst = state;
            cyc++;
         end
      end
      run_btn = 1'b1;
      for (int i = 0; i < 27; i++) begin
         if (i == 15) run_btn = 1'b0;
         step(1);
         if (state !== prevst) changes++;
         prevst = state;
      end
      checks++;
      if (changes != 1) begin
         errors++;
         $display("FAIL bounce_changes: got %0d expected 1", changes);
      end
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL bounce_state: got %0d expected 1", state);
      end
   endtask

   task automatic test_halt();
      int tot, bl, db, seen;
      seen = 0;
      tick_clk = 1'b1;
      step(3);
      halt_req = 1'b1;
      step(1);
      checks++;
      if (cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL halt_en: got %b expected 0", cpu_en);
      end
      checks++;
      if (state !== 2'd3 || halted !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL halt_state: got %0d/%b/%b expected 3/1/0",
                  state, halted, running);
      end
      for (int i = 0; i < 12; i++) begin
         if (i == 2) tick_clk = 1'b0;
         step(1);
         if (cpu_en === 1'b1) seen++;
      end
      press(1'b1, 1'b0, 10);
      checks++;
      if (state !== 2'd3) begin
         errors++;
         $display("FAIL halt_ignore_btn: got %0d expected 3", state);
      end
      run_ticks(2, 0, tot, bl, db);
      checks++;
      if (tot + seen != 0) begin
         errors++;
         $display("FAIL halt_no_en: got %0d expected 0", tot + seen);
      end
      halt_req = 1'b0;
      step(3);
      checks++;
      if (state !== 2'd3) begin
         errors++;
         $display("FAIL halt_hold: got %0d expected 3", state);
      end
      press(1'b1, 1'b0, 10);
      checks++;
      if (state !== 2'd1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_resume: got %0d/%b expected 1/0", state, halted);
      end
      checks++;
      if (cycle_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL halt_cnt: got %0d expected %0d", cycle_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int tot, bl, db;
      press(1'b1, 1'b0, 10);
      press(1'b1, 1'b1, 10);
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL both_btn: got %0d expected 1", state);
      end
      run_ticks(4, 0, tot, bl, db);
      exp_cnt = (exp_cnt + 4) % MODN;
      checks++;
      if (tot != 4 || db != 0 || bl != 0) begin
         errors++;
         $display("FAIL both_ticks: got %0d/%0d/%0d expected 4/0/0",
                  tot, db, bl);
      end
      checks++;
      if (cycle_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL both_cnt: got %0d expected %0d", cycle_cnt, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      int tot, bl, db, seen;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      exp_cnt = 0;
      press(1'b1, 1'b0, 10);
      run_ticks(17, 0, tot, bl, db);
      exp_cnt = (exp_cnt + 17) % MODN;
      checks++;
      if (tot != 17 || db != 0) begin
         errors++;
         $display("FAIL wrap_pulses: got %0d/%0d expected 17/0", tot, db);
      end
      checks++;
      if (cycle_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL wrap_cnt: got %0d expected %0d", cycle_cnt, exp_cnt);
      end
      tick_clk = 1'b1;
      step(2);
      rst = 1'b1;
      step(1);
      checks++;
      if (state !== 2'd0 || cycle_cnt !== 4'd0 || cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst: got %0d/%0d/%b expected 0/0/0",
                  state, cycle_cnt, cpu_en);
      end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) tick_clk = 1'b0;
         step(1);
         if (cpu_en === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || state !== 2'd0) begin
         errors++;
         $display("FAIL rst_discard: got %0d/%0d expected 0/0", seen, state);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_step();
      test_bounce();
      test_halt();
      test_back_to_back();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
